regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port CPU register file; successor to the 2R/1W file.
//  Adds configurable width/depth/port counts, same-cycle write-to-read bypass,
//  deterministic write-port priority and a per-register busy scoreboard.
//  Sits in decode/writeback of the pipelined core; the scoreboard drives hazard stalls.
// PARAMETERS
//  DATA_W   32  data width per register
//  ADDR_W   5   address width; depth = 2**ADDR_W
//  NREAD    2   number of read ports (>=1)
//  NWRITE   2   number of write ports (>=1)
//  BYPASS   1   1: same-cycle write data is forwarded to read ports; 0: reads see stored value
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, is never busy
// PORTS
//  clk       in   1               rising-edge clock
//  rst       in   1               asynchronous, active-high reset
//  ra        in   NREAD*ADDR_W    read addresses; port i = ra[i*ADDR_W +: ADDR_W]
//  rd        out  NREAD*DATA_W    read data; port i = rd[i*DATA_W +: DATA_W]
//  rbusy     out  NREAD           1 = register at ra[i] has an outstanding producer
//  we        in   NWRITE          write enables
//  wa        in   NWRITE*ADDR_W   write addresses
//  wd        in   NWRITE*DATA_W   write data
//  rsv_en    in   1               reserve: mark rsv_addr busy (instruction issued)
//  rsv_addr  in   ADDR_W          register to reserve
//  flush     in   1               clear every busy bit (pipeline flush); data unchanged
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by system): all registers <= 0, all busy <= 0.
//    While rst=1: rd = 0 on every port, rbusy = 0. No write/reserve takes effect.
//  - Reads: combinational, 0-cycle latency. rd[i] = mem[ra[i]] unless bypass applies.
//  - Writes: committed on rising clk. Port j writes iff we[j]=1 and
//    !(ZERO_REG && wa[j]==0). Multiple enabled ports to the same address:
//    highest index j wins; other ports to different addresses all commit.
//  - Bypass (BYPASS=1): if any enabled, non-suppressed write matches ra[i]
//    this cycle, rd[i] = wd of the highest-index matching port.
//  - ZERO_REG=1: ra[i]==0 -> rd[i]=0, rbusy[i]=0 regardless of writes/bypass.
//  - Scoreboard busy[ADDR] (registered), next-state per address a, priority order:
//      1. flush=1                           -> busy[a] <= 0 (overrides everything)
//      2. rsv_en=1 && rsv_addr==a           -> busy[a] <= 1 (new producer beats a completing write)
//      3. any committed write to a          -> busy[a] <= 0
//      4. else                              -> hold
//    Reserve of address 0 with ZERO_REG=1 ignored.
//  - rbusy[i] = busy[ra[i]], except 0 when BYPASS=1 and a write to ra[i] commits
//    this cycle (data is forwarded). A reserve only shows on rbusy next cycle.
//  - Write to a non-busy register is legal and clears nothing extra.
//  - Reset mid-operation: in-flight writes, reserves and flush that cycle are discarded.
//  - All addresses in range by construction (depth = 2**ADDR_W); no wrap logic needed.
// TESTING
//  1 Reset: preload regs, assert rst mid-cycle -> rd=0 and rbusy=0 immediately; after
//    release, ra0=7 reads 0x00000000.
//  2 Write/read: we[0]=1 wa0=5 wd0=0xDEADBEEF, edge; next cycle ra1=5 -> rd1=0xDEADBEEF.
//    Same cycle with BYPASS=1 -> rd1=0xDEADBEEF already; BYPASS=0 -> old value.
//  3 Port conflict: we=2'b11, wa0=wa1=9, wd0=0x11, wd1=0x22 -> reg9=0x22; bypass read
//    of 9 same cycle = 0x22.
//  4 Zero reg: we[0]=1 wa0=0 wd0=0xFFFF_FFFF, rsv_en=1 rsv_addr=0 -> ra=0 gives rd=0, rbusy=0.
//  5 Scoreboard: rsv 12 -> next cycle rbusy=1 for ra=12; write 12 with rsv 12 same
//    cycle -> stays busy; write 12 alone -> rbusy=0 that cycle (bypass) and after.
//  6 Flush: reserve regs 3,4,5; flush=1 with rsv_en=1 rsv_addr=6 -> all busy=0 next
//    cycle, including 6; register contents unchanged.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass, write-port priority
// and a per-register busy scoreboard used for hazard stalls.

// One read lane: combinational lookup plus bypass and scoreboard view.
module regfile_mp_rport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NWRITE   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 1 << ADDR_W
) (
  input  logic                               rst,
  input  logic [ADDR_W-1:0]                  ra,
  input  logic [DEPTH-1:0][DATA_W-1:0]       mem,
  input  logic [DEPTH-1:0]                   busy,
  input  logic [NWRITE-1:0]                  wcommit,
  input  logic [NWRITE-1:0][ADDR_W-1:0]      wa,
  input  logic [NWRITE-1:0][DATA_W-1:0]      wd,
  output logic [DATA_W-1:0]                  rd,
  output logic                               rbusy
);

  // Stored value, overridden by the highest-index committing write, then by
  // the hardwired zero register, then by reset.
  always_comb begin
    rd    = mem[ra];
    rbusy = busy[ra];
    for (int j = 0; j < NWRITE; j++) begin
      if (BYPASS != 0 && wcommit[j] && wa[j] == ra) begin
        rd    = wd[j];
        rbusy = 1'b0;
      end
    end
    if (ZERO_REG != 0 && ra == '0) begin
      rd    = '0;
      rbusy = 1'b0;
    end
    if (rst) begin
      rd    = '0;
      rbusy = 1'b0;
    end
  end

endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*ADDR_W-1:0]  ra,
  output logic [NREAD*DATA_W-1:0]  rd,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] wa,
  input  logic [NWRITE*DATA_W-1:0] wd,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [NWRITE-1:0][ADDR_W-1:0] wa_v;
  logic [NWRITE-1:0][DATA_W-1:0] wd_v;
  logic [NWRITE-1:0]             wcommit;
  logic                          rsv_ok;
  logic [DEPTH-1:0][DATA_W-1:0]  mem, mem_nxt;
  logic [DEPTH-1:0]              busy, busy_nxt;

  assign wa_v = wa;
  assign wd_v = wd;

  // A write commits unless it targets the hardwired zero register.
  always_comb begin
    wcommit = '0;
    for (int j = 0; j < NWRITE; j++)
      wcommit[j] = we[j] && !(ZERO_REG != 0 && wa_v[j] == '0);
  end

  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  // Next state: ascending port loop so the highest index wins a conflict;
  // reserve beats a completing write, flush beats everything.
  always_comb begin
    mem_nxt  = mem;
    busy_nxt = busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (wcommit[j]) begin
        mem_nxt[wa_v[j]]  = wd_v[j];
        busy_nxt[wa_v[j]] = 1'b0;
      end
    end
    if (rsv_ok)
      busy_nxt[rsv_addr] = 1'b1;
    if (flush)
      busy_nxt = '0;
  end

  // Register array and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      mem  <= mem_nxt;
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rp
    regfile_mp_rport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NWRITE  (NWRITE),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG),
      .DEPTH   (DEPTH)
    ) u_rp (
      .rst    (rst),
      .ra     (ra[i*ADDR_W +: ADDR_W]),
      .mem    (mem),
      .busy   (busy),
      .wcommit(wcommit),
      .wa     (wa_v),
      .wd     (wd_v),
      .rd     (rd[i*DATA_W +: DATA_W]),
      .rbusy  (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing instance and a non-bypassing
// instance share stimulus; expectations are queued and drained at sample time.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd, rd_nb;
  logic [NR-1:0]     rbusy, rbusy_nb;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*DW-1:0]  wd;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              flush;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          port;
    bit          nb;
    logic [31:0] d;
    logic        b;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW),
               .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .NWRITE(NW),
               .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .flush(flush));

  task automatic exp(input string tag, input int p, input logic [31:0] d,
                     input logic b, input bit nb);
    exp_t e;
    e.tag = tag; e.port = p; e.nb = nb; e.d = d; e.b = b;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] gd;
    logic        gb;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      gd = e.nb ? rd_nb[e.port*DW +: DW] : rd[e.port*DW +: DW];
      gb = e.nb ? rbusy_nb[e.port] : rbusy[e.port];
      checks++;
      assert (gd === e.d) else begin
        errors++;
        $error("FAIL %s%s rd%0d: got %h expected %h", e.tag, e.nb ? "/nb" : "", e.port, gd, e.d);
      end
      checks++;
      assert (gb === e.b) else begin
        errors++;
        $error("FAIL %s%s rbusy%0d: got %b expected %b", e.tag, e.nb ? "/nb" : "", e.port, gb, e.b);
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    we = '0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic wr(input int j, input logic [AW-1:0] a, input logic [31:0] d);
    we[j] = 1'b1;
    wa[j*AW +: AW] = a;
    wd[j*DW +: DW] = d;
  endtask

  task automatic setra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    rst = 1'b1; ra = '0; we = '0; wa = '0; wd = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;

    // reset state
    @(posedge clk); #1;
    setra(0, 5'd7); setra(1, 5'd9);
    #1;
    exp("rst_init", 0, 32'h0, 1'b0, 0);
    exp("rst_init", 1, 32'h0, 1'b0, 0);
    drain();
    rst = 1'b0;

    // preload reg7 and reserve it, then reset mid-cycle
    step(); wr(0, 5'd7, 32'h77); rsv(5'd7);
    step();
    exp("preload", 0, 32'h77, 1'b1, 0);
    exp("preload", 0, 32'h77, 1'b1, 1);
    sample();
    #1 rst = 1'b1;
    #1;
    exp("rst_mid", 0, 32'h0, 1'b0, 0);
    exp("rst_mid", 0, 32'h0, 1'b0, 1);
    drain();
    @(posedge clk); #1 rst = 1'b0;
    exp("rst_after", 0, 32'h0, 1'b0, 0);
    sample();

    // write then read; bypass vs stored value
    step(); wr(0, 5'd5, 32'hDEADBEEF); setra(1, 5'd5);
    exp("wr_byp", 1, 32'hDEADBEEF, 1'b0, 0);
    exp("wr_byp", 1, 32'h0, 1'b0, 1);
    sample();
    step();
    exp("wr_rd", 1, 32'hDEADBEEF, 1'b0, 0);
    exp("wr_rd", 1, 32'hDEADBEEF, 1'b0, 1);
    sample();

    // same-address port conflict: higher port wins
    step(); wr(0, 5'd9, 32'h11); wr(1, 5'd9, 32'h22); setra(0, 5'd9);
    exp("conf_byp", 0, 32'h22, 1'b0, 0);
    exp("conf_byp", 0, 32'h0, 1'b0, 1);
    sample();
    step();
    exp("conf_rd", 0, 32'h22, 1'b0, 0);
    exp("conf_rd", 0, 32'h22, 1'b0, 1);
    sample();

    // two ports to different addresses both commit
    step(); wr(0, 5'd10, 32'hA0A0); wr(1, 5'd11, 32'hB1B1); setra(0, 5'd10); setra(1, 5'd11);
    step();
    exp("dual_wr", 0, 32'hA0A0, 1'b0, 1);
    exp("dual_wr", 1, 32'hB1B1, 1'b0, 1);
    sample();

    // zero register ignores writes and reserves
    step(); wr(0, 5'd0, 32'hFFFFFFFF); rsv(5'd0); setra(0, 5'd0); setra(1, 5'd0);
    exp("zero_now", 0, 32'h0, 1'b0, 0);
    exp("zero_now", 1, 32'h0, 1'b0, 1);
    sample();
    step();
    exp("zero_next", 0, 32'h0, 1'b0, 0);
    exp("zero_next", 1, 32'h0, 1'b0, 1);
    sample();

    // scoreboard: reserve visible next cycle
    step(); rsv(5'd12); setra(0, 5'd12);
    exp("rsv_now", 0, 32'h0, 1'b0, 0);
    sample();
    step();
    exp("rsv_next", 0, 32'h0, 1'b1, 0);
    exp("rsv_next", 0, 32'h0, 1'b1, 1);
    sample();
    // write plus re-reserve: stays busy
    step(); wr(0, 5'd12, 32'h00C0FFEE); rsv(5'd12);
    exp("wr_rsv_now", 0, 32'h00C0FFEE, 1'b0, 0);
    exp("wr_rsv_now", 0, 32'h0, 1'b1, 1);
    sample();
    step();
    exp("wr_rsv_next", 0, 32'h00C0FFEE, 1'b1, 0);
    exp("wr_rsv_next", 0, 32'h00C0FFEE, 1'b1, 1);
    sample();
    // write alone clears busy
    step(); wr(1, 5'd12, 32'h1234);
    exp("wr_clr_now", 0, 32'h1234, 1'b0, 0);
    exp("wr_clr_now", 0, 32'h00C0FFEE, 1'b1, 1);
    sample();
    step();
    exp("wr_clr_next", 0, 32'h1234, 1'b0, 0);
    exp("wr_clr_next", 0, 32'h1234, 1'b0, 1);
    sample();

    // flush clears all busy bits, including a same-cycle reserve
    step(); rsv(5'd3);
    step(); rsv(5'd4);
    step(); rsv(5'd5);
    step(); setra(0, 5'd3); setra(1, 5'd5);
    exp("pre_flush", 0, 32'h0, 1'b1, 0);
    exp("pre_flush", 1, 32'hDEADBEEF, 1'b1, 0);
    sample();
    step(); flush = 1'b1; rsv(5'd6); setra(0, 5'd6);
    exp("flush_now", 0, 32'h0, 1'b0, 0);
    exp("flush_now", 1, 32'hDEADBEEF, 1'b1, 0);
    sample();
    step();
    exp("flush_6", 0, 32'h0, 1'b0, 0);
    exp("flush_5", 1, 32'hDEADBEEF, 1'b0, 0);
    exp("flush_5", 1, 32'hDEADBEEF, 1'b0, 1);
    sample();
    #1 setra(0, 5'd4); setra(1, 5'd9);
    #1;
    exp("flush_4", 0, 32'h0, 1'b0, 0);
    exp("flush_data", 1, 32'h22, 1'b0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
